// File: rtl/instr_mem_loader_if.sv
// Loader/fetch bus for instr_mem_loader.
// master: program loader plus fetch stage. slave: the instruction memory.
interface instr_mem_loader_if #(
  parameter int INSTR_W = 9,
  parameter int ADDR_W  = 10
);
  logic               load_start;
  logic               ld_valid;
  logic               ld_ready;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic [ADDR_W-1:0]  pc;
  logic               fetch_en;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               run;
  logic [ADDR_W:0]    load_count;
  logic               ovf_err;
  logic               par_err;

  modport master (
    output load_start, ld_valid, ld_data, ld_last, pc, fetch_en,
    input  ld_ready, instr, instr_valid, run, load_count, ovf_err, par_err
  );

  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, pc, fetch_en,
    output ld_ready, instr, instr_valid, run, load_count, ovf_err, par_err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Runtime-loadable instruction memory for the 9-bit CPU.
// A program is streamed in over a valid/ready port (EMPTY -> LOAD -> RUN),
// after which fetches are served with one cycle of latency. Addresses at or
// beyond the loaded length return FILL.
// Optional macro PARITY_CHECK_EN: stores an even-parity bit per word and
// flags a mismatch on fetch through par_err (tied 0 when undefined).
module instr_mem_loader #(
  parameter int                 INSTR_W = 9,
  parameter int                 ADDR_W  = 10,
  parameter int                 DEPTH   = 1 << ADDR_W,
  parameter logic [INSTR_W-1:0] FILL    = '0
) (
  input  logic                clk,
  input  logic                reset,
  instr_mem_loader_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
`ifdef PARITY_CHECK_EN
  localparam int MEM_W = INSTR_W + 1;
`else
  localparam int MEM_W = INSTR_W;
`endif

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W:0]    wptr_reg;        // also the visible load_count
  logic [INSTR_W-1:0] instr_reg;
  logic               instr_valid_reg;
  logic               ovf_reg;

  logic [MEM_W-1:0]   mem [DEPTH];

  logic               ld_ready_c;
  logic               hs;
  logic               at_last;
  logic               ovf_set;
  logic               fetch_do;
  logic               in_range;
  logic [AW-1:0]      waddr;
  logic [AW-1:0]      raddr;
  logic [MEM_W-1:0]   wdata;
  logic [MEM_W-1:0]   rword;

  // load_start always wins, so the loader never sees ready during a restart
  assign ld_ready_c = (state_reg == LOAD) & ~bus.load_start;
  assign hs         = bus.ld_valid & ld_ready_c;
  assign at_last    = (wptr_reg == LAST_PTR);
  assign waddr      = wptr_reg[AW-1:0];
  assign raddr      = bus.pc[AW-1:0];
  assign in_range   = ({1'b0, bus.pc} < wptr_reg);
  assign rword      = mem[raddr];

`ifdef PARITY_CHECK_EN
  assign wdata = {^bus.ld_data, bus.ld_data};
`else
  assign wdata = bus.ld_data;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= EMPTY;
    else       state_reg <= state_next;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_next = state_reg;
    ovf_set    = 1'b0;
    fetch_do   = 1'b0;
    case (state_reg)
      EMPTY: ;
      LOAD: begin
        if (hs && (bus.ld_last || at_last)) state_next = RUN;
        ovf_set = hs & ~bus.ld_last & at_last;
      end
      RUN:     fetch_do = bus.fetch_en;
      default: state_next = EMPTY;
    endcase
    if (bus.load_start) begin
      state_next = LOAD;
      fetch_do   = 1'b0;
    end
  end

  // Program storage: written only on an accepted loader word, never cleared
  always_ff @(posedge clk) begin
    if (hs) mem[waddr] <= wdata;
  end

  // Write pointer, fetch output register and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg        <= '0;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      ovf_reg         <= 1'b0;
    end else if (bus.load_start) begin
      wptr_reg        <= '0;
      instr_valid_reg <= 1'b0;
      ovf_reg         <= 1'b0;
    end else begin
      if (hs)      wptr_reg <= wptr_reg + 1'b1;
      if (ovf_set) ovf_reg  <= 1'b1;
      instr_valid_reg <= fetch_do;
      if (fetch_do) instr_reg <= in_range ? rword[INSTR_W-1:0] : FILL;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_reg;

  // Parity result of the latest fetch; FILL fetches never flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               par_reg <= 1'b0;
    else if (bus.load_start) par_reg <= 1'b0;
    else if (fetch_do)       par_reg <= in_range & (^rword);
  end

  assign bus.par_err = par_reg;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.ld_ready    = ld_ready_c;
  assign bus.run         = (state_reg == RUN);
  assign bus.instr       = instr_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.load_count  = wptr_reg;
  assign bus.ovf_err     = ovf_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a full-depth instance (a) and a
// DEPTH=4 instance (b) for the overflow path. A reference image (array plus
// loaded length) predicts every fetch.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] model_mem [1024];
  int         model_count = 0;

  instr_mem_loader_if #(.INSTR_W(9), .ADDR_W(10)) a ();
  instr_mem_loader_if #(.INSTR_W(9), .ADDR_W(10)) b ();

  instr_mem_loader #(.INSTR_W(9), .ADDR_W(10)) dut_a (.clk(clk), .reset(reset), .bus(a));
  instr_mem_loader #(.INSTR_W(9), .ADDR_W(10), .DEPTH(4)) dut_b (.clk(clk), .reset(reset), .bus(b));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] exp_fetch(input int p);
    return (p < model_count) ? model_mem[p] : 9'h000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word on port a until accepted (bounded); updates the model.
  task automatic send_a(input logic [8:0] d, input logic last, output bit ok);
    ok = 1'b0;
    a.ld_valid = 1'b1; a.ld_data = d; a.ld_last = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (a.ld_ready) ok = 1'b1;
      tick();
    end
    a.ld_valid = 1'b0; a.ld_last = 1'b0;
    if (ok) begin
      model_mem[model_count] = d;
      model_count++;
    end
  endtask

  task automatic start_a();
    a.load_start = 1'b1;
    tick();
    a.load_start = 1'b0;
    model_count = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (a.run !== 1'b0 || a.ld_ready !== 1'b0 || a.instr !== 9'h0 || a.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_outs run=%b rdy=%b instr=%h iv=%b exp all 0", a.run, a.ld_ready, a.instr, a.instr_valid); end
    checks++; if (a.load_count !== 11'd0 || a.ovf_err !== 1'b0 || a.par_err !== 1'b0) begin errors++; $display("FAIL reset_cnt cnt=%0d ovf=%b par=%b exp 0", a.load_count, a.ovf_err, a.par_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_empty();
    a.fetch_en = 1'b1; a.pc = 10'd0; a.ld_valid = 1'b1;
    #1;
    checks++; if (a.ld_ready !== 1'b0) begin errors++; $display("FAIL empty_ready got %b exp 0", a.ld_ready); end
    tick();
    checks++; if (a.instr_valid !== 1'b0 || a.load_count !== 11'd0) begin errors++; $display("FAIL empty_ignore iv=%b cnt=%0d exp 0 0", a.instr_valid, a.load_count); end
    a.fetch_en = 1'b0; a.ld_valid = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    logic [8:0] prog [3];
    prog[0] = 9'h1E0; prog[1] = 9'h031; prog[2] = 9'h103;
    start_a();
    for (int i = 0; i < 3; i++) begin
      send_a(prog[i], i == 2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_hs word %0d got no-accept exp accept", i); end
      if (i == 1) begin
        checks++; if (a.run !== 1'b0) begin errors++; $display("FAIL basic_run_early got %b exp 0", a.run); end
      end
    end
    checks++; if (a.run !== 1'b1 || a.load_count !== 11'd3) begin errors++; $display("FAIL basic_run run=%b cnt=%0d exp 1 3", a.run, a.load_count); end
    a.pc = 10'd1; a.fetch_en = 1'b1;
    tick();
    a.fetch_en = 1'b0;
    checks++; if (a.instr !== exp_fetch(1) || a.instr_valid !== 1'b1) begin errors++; $display("FAIL basic_fetch instr=%h iv=%b exp %h 1", a.instr, a.instr_valid, exp_fetch(1)); end
  endtask

  task automatic test_fill_hold();
    a.pc = 10'd0; a.fetch_en = 1'b1;
    tick();
    a.fetch_en = 1'b0;
    tick();
    checks++; if (a.instr !== exp_fetch(0) || a.instr_valid !== 1'b0) begin errors++; $display("FAIL hold_word instr=%h iv=%b exp %h 0", a.instr, a.instr_valid, exp_fetch(0)); end
    a.pc = 10'd5; a.fetch_en = 1'b1;
    tick();
    a.fetch_en = 1'b0;
    checks++; if (a.instr !== 9'h000 || a.instr_valid !== 1'b1) begin errors++; $display("FAIL fill_fetch instr=%h iv=%b exp 000 1", a.instr, a.instr_valid); end
    tick();
    checks++; if (a.instr !== 9'h000 || a.instr_valid !== 1'b0) begin errors++; $display("FAIL fill_hold instr=%h iv=%b exp 000 0", a.instr, a.instr_valid); end
  endtask

  task automatic test_gaps();
    bit ok;
    start_a();
    for (int i = 0; i < 4; i++) begin
      send_a(9'($urandom), i == 3, ok);
      checks++; if (!ok || a.load_count !== 11'(i + 1)) begin errors++; $display("FAIL gap_step ok=%b cnt=%0d exp 1 %0d", ok, a.load_count, i + 1); end
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          checks++; if (a.load_count !== 11'(i + 1)) begin errors++; $display("FAIL gap_idle cnt=%0d exp %0d", a.load_count, i + 1); end
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      a.pc = 10'(p); a.fetch_en = 1'b1;
      tick();
      checks++; if (a.instr !== exp_fetch(p) || a.instr_valid !== 1'b1) begin errors++; $display("FAIL gap_read pc=%0d instr=%h iv=%b exp %h 1", p, a.instr, a.instr_valid, exp_fetch(p)); end
    end
    a.fetch_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    int p;
    logic [8:0] last_exp;
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 24));
      start_a();
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_a(9'($urandom), i == n - 1, ok);
        if (!ok) begin checks++; errors++; $display("FAIL b2b_hs word %0d got no-accept exp accept", i); end
      end
      checks++; if (a.run !== 1'b1 || a.load_count !== 11'(n)) begin errors++; $display("FAIL b2b_loaded run=%b cnt=%0d exp 1 %0d", a.run, a.load_count, n); end
      a.fetch_en = 1'b1;
      last_exp = 9'h0;
      for (int k = 0; k < 20; k++) begin
        p = int'($urandom_range(0, n + 5));
        a.pc = 10'(p);
        tick();
        last_exp = exp_fetch(p);
        checks++; if (a.instr !== last_exp || a.instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_fetch pc=%0d instr=%h iv=%b exp %h 1", p, a.instr, a.instr_valid, last_exp); end
      end
      a.fetch_en = 1'b0;
      tick();
      checks++; if (a.instr !== last_exp || a.instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold instr=%h iv=%b exp %h 0", a.instr, a.instr_valid, last_exp); end
    end
  endtask

  task automatic test_overflow();
    logic [8:0] w [4];
    b.load_start = 1'b1;
    tick();
    b.load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w[i] = 9'($urandom);
      b.ld_valid = 1'b1; b.ld_data = w[i]; b.ld_last = 1'b0;
      #1;
      checks++; if (b.ld_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready word %0d got 0 exp 1", i); end
      tick();
    end
    b.ld_data = ~w[0];
    #1;
    checks++; if (b.ld_ready !== 1'b0 || b.run !== 1'b1 || b.ovf_err !== 1'b1 || b.load_count !== 11'd4) begin errors++; $display("FAIL ovf_state rdy=%b run=%b ovf=%b cnt=%0d exp 0 1 1 4", b.ld_ready, b.run, b.ovf_err, b.load_count); end
    tick(); tick();
    b.ld_valid = 1'b0;
    checks++; if (b.load_count !== 11'd4 || b.ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_nowrite cnt=%0d ovf=%b exp 4 1", b.load_count, b.ovf_err); end
    b.fetch_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      b.pc = 10'(p);
      tick();
      checks++; if (b.instr !== w[p]) begin errors++; $display("FAIL ovf_read pc=%0d instr=%h exp %h", p, b.instr, w[p]); end
    end
    b.fetch_en = 1'b0;
    b.load_start = 1'b1;
    tick();
    b.load_start = 1'b0;
    checks++; if (b.ovf_err !== 1'b0 || b.load_count !== 11'd0 || b.run !== 1'b0) begin errors++; $display("FAIL ovf_clear ovf=%b cnt=%0d run=%b exp 0 0 0", b.ovf_err, b.load_count, b.run); end
  endtask

  task automatic test_restart();
    bit ok;
    start_a();
    for (int i = 0; i < 2; i++) send_a(9'($urandom), 1'b0, ok);
    checks++; if (a.load_count !== 11'd2) begin errors++; $display("FAIL rst_partial cnt=%0d exp 2", a.load_count); end
    a.ld_valid = 1'b1; a.ld_data = 9'h155; a.ld_last = 1'b1; a.load_start = 1'b1;
    #1;
    checks++; if (a.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", a.ld_ready); end
    tick();
    a.load_start = 1'b0; a.ld_valid = 1'b0; a.ld_last = 1'b0;
    model_count = 0;
    checks++; if (a.load_count !== 11'd0 || a.run !== 1'b0 || a.ovf_err !== 1'b0) begin errors++; $display("FAIL rst_clear cnt=%0d run=%b ovf=%b exp 0 0 0", a.load_count, a.run, a.ovf_err); end
    send_a(9'($urandom_range(1, 511)), 1'b0, ok);
    send_a(9'($urandom_range(1, 511)), 1'b1, ok);
    a.fetch_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      a.pc = 10'(p);
      tick();
      checks++; if (a.instr !== exp_fetch(p) || a.instr_valid !== 1'b1) begin errors++; $display("FAIL rst_reload pc=%0d instr=%h iv=%b exp %h 1", p, a.instr, a.instr_valid, exp_fetch(p)); end
    end
    a.fetch_en = 1'b0;
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    dut_a.mem[1][0] = ~dut_a.mem[1][0];
    a.pc = 10'd1; a.fetch_en = 1'b1;
    tick();
    checks++; if (a.par_err !== 1'b1 || a.instr_valid !== 1'b1) begin errors++; $display("FAIL par_flag par=%b iv=%b exp 1 1", a.par_err, a.instr_valid); end
    a.pc = 10'd0;
    tick();
    a.fetch_en = 1'b0;
    checks++; if (a.par_err !== 1'b0) begin errors++; $display("FAIL par_clear par=%b exp 0", a.par_err); end
  endtask
`endif

  task automatic test_async_reset();
    a.pc = 10'd0; a.fetch_en = 1'b1;
    tick();
    checks++; if (a.instr !== exp_fetch(0) || a.instr_valid !== 1'b1 || a.run !== 1'b1) begin errors++; $display("FAIL areset_pre instr=%h iv=%b run=%b exp %h 1 1", a.instr, a.instr_valid, a.run, exp_fetch(0)); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (a.run !== 1'b0 || a.instr !== 9'h0 || a.instr_valid !== 1'b0 || a.load_count !== 11'd0) begin errors++; $display("FAIL areset run=%b instr=%h iv=%b cnt=%0d exp 0 000 0 0", a.run, a.instr, a.instr_valid, a.load_count); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (a.instr_valid !== 1'b0 || a.run !== 1'b0) begin errors++; $display("FAIL areset_empty iv=%b run=%b exp 0 0", a.instr_valid, a.run); end
    a.fetch_en = 1'b0;
  endtask

  initial begin
    a.load_start = 1'b0; a.ld_valid = 1'b0; a.ld_data = '0; a.ld_last = 1'b0; a.pc = '0; a.fetch_en = 1'b0;
    b.load_start = 1'b0; b.ld_valid = 1'b0; b.ld_data = '0; b.ld_last = 1'b0; b.pc = '0; b.fetch_en = 1'b0;
    #1;
    test_reset();
    test_empty();
    test_basic();
    test_fill_hold();
    test_gaps();
    test_back_to_back();
    test_overflow();
    test_restart();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
